// File: rtl/pipe_ins_tracker_pkg.sv
// Shared constants for the pipeline instruction tracker and the hazard unit:
// reset/bubble words, MIPS opcode/funct codes, instruction bit fields, stage record.
package pipe_ins_tracker_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;   // sll $0,$0,0

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ins;
    } stage_t;

    function automatic logic [5:0] insOp(input logic [31:0] ins);
        return ins[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] insRs(input logic [31:0] ins);
        return ins[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] insRt(input logic [31:0] ins);
        return ins[RT_HI:RT_LO];
    endfunction

    function automatic logic [4:0] insRd(input logic [31:0] ins);
        return ins[RD_HI:RD_LO];
    endfunction

    function automatic logic [5:0] insFunct(input logic [31:0] ins);
        return ins[FN_HI:FN_LO];
    endfunction

endpackage

// File: rtl/pipe_ins_tracker_stage_reg.sv
// One pipeline stage record {vld, pc, ins}: holds when en=0, loads a bubble when clr=1.
module stage_reg
    import pipe_ins_tracker_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   clr,
    input  stage_t dIn,
    output stage_t q
);

    localparam stage_t BUBBLE = '{vld: 1'b0, pc: 32'h0, ins: NOP_WORD};

    // clr wins over en so a bubble lands even if a stage is ever both held and cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= BUBBLE;
        end else if (clr) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= dIn;
        end
    end

endmodule

// File: rtl/pipe_ins_tracker.sv
// F->D->E->M->W instruction/PC/valid chain; stall freezes F/D, bubbles E, and is
// counted in a saturating debug counter. All outputs come straight from flops.
module pipe_ins_tracker
    import pipe_ins_tracker_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      next_pc,
    input  logic [31:0]      instr_f,
    output logic [31:0]      pc_f,
    output logic [31:0]      ins_d,
    output logic [31:0]      ins_e,
    output logic [31:0]      ins_m,
    output logic [31:0]      ins_w,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc_e,
    output logic [31:0]      pc_m,
    output logic [31:0]      pc_w,
    output logic             vld_d,
    output logic             vld_e,
    output logic             vld_m,
    output logic             vld_w,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_t fetchStage;
    stage_t stgD;
    stage_t stgE;
    stage_t stgM;
    stage_t stgW;

    always_comb begin
        fetchStage = '{vld: 1'b1, pc: pc_f, ins: instr_f};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f <= PC_RESET;
        end else if (!stall) begin
            pc_f <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    stage_reg #(.NOP_WORD(NOP_WORD)) uStageD (
        .clk(clk), .reset(reset), .en(~stall), .clr(1'b0), .dIn(fetchStage), .q(stgD)
    );

    stage_reg #(.NOP_WORD(NOP_WORD)) uStageE (
        .clk(clk), .reset(reset), .en(1'b1), .clr(stall), .dIn(stgD), .q(stgE)
    );

    stage_reg #(.NOP_WORD(NOP_WORD)) uStageM (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .dIn(stgE), .q(stgM)
    );

    stage_reg #(.NOP_WORD(NOP_WORD)) uStageW (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .dIn(stgM), .q(stgW)
    );

    assign ins_d = stgD.ins;
    assign ins_e = stgE.ins;
    assign ins_m = stgM.ins;
    assign ins_w = stgW.ins;
    assign pc_d  = stgD.pc;
    assign pc_e  = stgE.pc;
    assign pc_m  = stgM.pc;
    assign pc_w  = stgW.pc;
    assign vld_d = stgD.vld;
    assign vld_e = stgE.vld;
    assign vld_m = stgM.vld;
    assign vld_w = stgW.vld;

endmodule

// File: tb/tb_pipe_ins_tracker.sv
// Directed bench for pipe_ins_tracker: a 32-bit-counter instance and a CNT_W=4
// instance share all inputs, so the 4-bit one shows counter saturation.
module tb_pipe_ins_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        brTaken = 1'b0;
    logic [31:0] nextPc;
    logic [31:0] instrF;

    logic [31:0] pcF, insD, insE, insM, insW, pcD, pcE, pcM, pcW;
    logic        vldD, vldE, vldM, vldW;
    logic [31:0] stallCnt;

    logic [31:0] pcF4, insD4, insE4, insM4, insW4, pcD4, pcE4, pcM4, pcW4;
    logic        vldD4, vldE4, vldM4, vldW4;
    logic [3:0]  stallCnt4;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] W_ORI1  = 32'h3401_0005;
    localparam logic [31:0] W_ORI2  = 32'h3402_0006;
    localparam logic [31:0] W_SW    = 32'hAC01_0000;
    localparam logic [31:0] W_LUI   = 32'h3C05_1234;
    localparam logic [31:0] W_LW    = 32'h8C21_0000;
    localparam logic [31:0] W_ADDU  = 32'h0021_1021;
    localparam logic [31:0] W_BEQ   = 32'h1000_0004;
    localparam logic [31:0] W_SLOT  = 32'h3406_0009;
    localparam logic [31:0] W_TGT   = 32'h3407_000A;

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        case (a)
            32'h3000: return W_ORI1;
            32'h3004: return W_ORI2;
            32'h3008: return W_SW;
            32'h300C: return W_LUI;
            32'h3010: return W_LW;
            32'h3014: return W_ADDU;
            32'h3018: return W_BEQ;
            32'h301C: return W_SLOT;
            32'h302C: return W_TGT;
            default:  return {16'hFEED, a[15:0]};
        endcase
    endfunction

    assign instrF = wordAt(pcF);
    assign nextPc = brTaken ? 32'h0000_302C : pcF + 32'd4;

    always #5 clk = ~clk;

    pipe_ins_tracker uDut (
        .clk(clk), .reset(reset), .stall(stall), .next_pc(nextPc), .instr_f(instrF),
        .pc_f(pcF), .ins_d(insD), .ins_e(insE), .ins_m(insM), .ins_w(insW),
        .pc_d(pcD), .pc_e(pcE), .pc_m(pcM), .pc_w(pcW),
        .vld_d(vldD), .vld_e(vldE), .vld_m(vldM), .vld_w(vldW), .stall_cnt(stallCnt)
    );

    pipe_ins_tracker #(.CNT_W(4)) uDut4 (
        .clk(clk), .reset(reset), .stall(stall), .next_pc(nextPc), .instr_f(instrF),
        .pc_f(pcF4), .ins_d(insD4), .ins_e(insE4), .ins_m(insM4), .ins_w(insW4),
        .pc_d(pcD4), .pc_e(pcE4), .pc_m(pcM4), .pc_w(pcW4),
        .vld_d(vldD4), .vld_e(vldE4), .vld_m(vldM4), .vld_w(vldW4), .stall_cnt(stallCnt4)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkResetState(input string tag);
        chk({tag, "_pcf"}, pcF, 32'h3000);
        chk({tag, "_ins"}, {insD, insE, insM, insW}, 128'h0);
        chk({tag, "_pc"},  {pcD, pcE, pcM, pcW}, 128'h0);
        chk({tag, "_vld"}, {vldD, vldE, vldM, vldW}, 4'b0000);
        chk({tag, "_cnt"}, {stallCnt, 28'h0, stallCnt4}, 64'h0);
        chk({tag, "_dut4"}, {pcF4, insD4, pcD4, 31'h0, vldD4}, {32'h3000, 96'h0});
    endtask

    initial begin
        // power-up reset
        #1 reset = 1'b1;
        #2;
        chkResetState("rst0");
        step();
        step();
        reset = 1'b0;

        // four free-running edges: first fetched word reaches W
        repeat (4) step();
        chk("w_ins",  insW, W_ORI1);
        chk("w_pc",   pcW, 32'h3000);
        chk("vld4",   {vldD, vldE, vldM, vldW}, 4'b1111);
        chk("d_ins4", {pcF, insD, pcD}, {32'h3010, W_LUI, 32'h300C});

        // lw in E, dependent addu in D
        repeat (2) step();
        chk("lw_e",   {insE, insD, pcF}, {W_LW, W_ADDU, 32'h3018});

        stall = 1'b1;
        step();
        chk("st1_fd", {pcF, insD, pcD}, {32'h3018, W_ADDU, 32'h3014});
        chk("st1_e",  {insE, pcE, 31'h0, vldE}, {64'h0, 32'h0});
        chk("st1_m",  {insM, 31'h0, vldM}, {W_LW, 32'h1});
        chk("st1_cnt", stallCnt, 32'd1);

        stall = 1'b0;
        step();
        chk("rel_e",  {insE, pcE, insD, pcF}, {W_ADDU, 32'h3014, W_BEQ, 32'h301C});
        chk("rel_mw", {insM, 31'h0, vldM, insW}, {32'h0, 32'h0, W_LW});

        // beq in D: delay slot enters D while the target loads into pc_f
        brTaken = 1'b1;
        step();
        chk("br_slot", {pcF, insD, pcD, insE}, {32'h302C, W_SLOT, 32'h301C, W_BEQ});
        brTaken = 1'b0;
        step();
        chk("br_tgt", {pcF, insD, pcD, insE}, {32'h3030, W_TGT, 32'h302C, W_SLOT});

        // asynchronous reset landing mid-cycle during a stall
        stall = 1'b1;
        step();
        chk("pre_rst_cnt", stallCnt, 32'd2);
        #3;
        stall = 1'bx;
        reset = 1'b1;
        #1;
        chkResetState("arst");
        step();
        chkResetState("arst_x");
        reset = 1'b0;
        stall = 1'b0;

        // two advances, then three consecutive stalls
        repeat (2) step();
        chk("pre3", {pcF, insD, insE}, {32'h3008, W_ORI2, W_ORI1});
        stall = 1'b1;
        step();
        chk("s3a", {pcF, insE, insM, insW, 28'h0, vldD, vldE, vldM, vldW},
                   {32'h3008, 32'h0, W_ORI1, 32'h0, 32'b1010});
        step();
        chk("s3b", {pcF, insE, insM, insW, 28'h0, vldD, vldE, vldM, vldW},
                   {32'h3008, 32'h0, 32'h0, W_ORI1, 32'b1001});
        step();
        chk("s3c", {pcF, insE, insM, insW, 28'h0, vldD, vldE, vldM, vldW},
                   {32'h3008, 32'h0, 32'h0, 32'h0, 32'b1000});
        chk("s3_cnt", {insD, pcD, stallCnt}, {W_ORI2, 32'h3004, 32'd3});
        stall = 1'b0;
        step();
        chk("s3_rel", {pcF, insD, insE, pcE}, {32'h300C, W_SW, W_ORI2, 32'h3004});

        // long stall: 4-bit counter saturates at 15, 32-bit keeps counting
        stall = 1'b1;
        repeat (11) step();
        chk("sat11", {stallCnt, 28'h0, stallCnt4}, {32'd14, 32'd14});
        step();
        chk("sat12", {stallCnt, 28'h0, stallCnt4}, {32'd15, 32'd15});
        step();
        chk("sat13", {stallCnt, 28'h0, stallCnt4}, {32'd16, 32'd15});
        repeat (7) step();
        chk("sat20", {stallCnt, 28'h0, stallCnt4}, {32'd23, 32'd15});
        chk("sat_fd",  {pcF, insD, pcD, 31'h0, vldD}, {32'h300C, W_SW, 32'h3008, 32'h1});
        chk("sat_emw", {insE, pcE, insM, pcM}, 128'h0);
        chk("sat_w",   {insW, pcW, 29'h0, vldE, vldM, vldW}, 96'h0);
        chk("sat4_fd", {pcF4, insD4, pcD4, 31'h0, vldD4}, {32'h300C, W_SW, 32'h3008, 32'h1});
        chk("sat4_emw", {insE4, pcE4, insM4, pcM4}, 128'h0);
        chk("sat4_w",  {insW4, pcW4, 29'h0, vldE4, vldM4, vldW4}, 96'h0);
        stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
